// File: rtl/pipe_reg.sv
// Parametrised pipeline register: STAGES stages of WIDTH-bit data, each with its own
// valid bit. Stages advance independently, so bubbles are squeezed out under backpressure.
module pipe_reg #(
  parameter int               WIDTH       = 16,
  parameter int               STAGES      = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  input  logic                              in_valid,
  input  logic [WIDTH-1:0]                  in_data,
  output logic                              in_ready,
  output logic                              out_valid,
  output logic [WIDTH-1:0]                  out_data,
  input  logic                              out_ready,
  output logic [$clog2(STAGES+1)-1:0]       occupancy
);

  localparam int OW = $clog2(STAGES + 1);

  logic [STAGES-1:0] v_q, v_d, adv_s;
  logic [WIDTH-1:0]  d_q [STAGES];
  logic [WIDTH-1:0]  d_d [STAGES];
  logic [OW-1:0]     occ_q, occ_d;

  // Source of each stage: index 0 is the upstream port, index i+1 is stage i.
  logic [STAGES:0]   src_v_s;
  logic [WIDTH-1:0]  src_d_s [STAGES+1];

  // Ready ripples from the output side back towards the input.
  always_comb begin
    logic a;
    a = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      a = ~v_q[i] | a;
      adv_s[i] = a;
    end
  end

  // Gather the per-stage source valid/data.
  always_comb begin
    src_v_s    = {v_q, in_valid};
    src_d_s[0] = in_data;
    for (int i = 0; i < STAGES; i++) begin
      src_d_s[i+1] = d_q[i];
    end
  end

  // Next-state of every stage and the population count that follows it.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush) begin
      v_d = {STAGES{1'b0}};
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (adv_s[i]) begin
          v_d[i] = src_v_s[i];
          if (src_v_s[i]) begin
            d_d[i] = src_d_s[i];
          end else begin
            d_d[i] = d_q[i];
          end
        end else begin
          v_d[i] = v_q[i];
          d_d[i] = d_q[i];
        end
      end
    end
    occ_d = {OW{1'b0}};
    for (int i = 0; i < STAGES; i++) begin
      occ_d = occ_d + OW'(v_d[i]);
    end
  end

  // Stage registers and occupancy counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= {STAGES{1'b0}};
      occ_q <= {OW{1'b0}};
      for (int i = 0; i < STAGES; i++) begin
        d_q[i] <= RESET_VALUE;
      end
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
      for (int i = 0; i < STAGES; i++) begin
        d_q[i] <= d_d[i];
      end
    end
  end

  assign in_ready  = adv_s[0] & ~flush;
  assign out_valid = v_q[STAGES-1];
  assign out_data  = d_q[STAGES-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_reg.sv
// Bench for pipe_reg: three configurations share one stimulus stream and are checked every
// cycle against a word-position model, plus hand-computed literal checkpoints.
module tb_pipe_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'h0000;
  logic        out_ready = 1'b0;

  logic [2:0]  ir, ov;
  logic [15:0] od0, od1;
  logic [7:0]  od2;
  logic [1:0]  occ0;
  logic [2:0]  occ1;
  logic [0:0]  occ2;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipe_reg #(.WIDTH(16), .STAGES(2), .RESET_VALUE(16'h0000)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir[0]), .out_valid(ov[0]), .out_data(od0), .out_ready(out_ready), .occupancy(occ0));
  pipe_reg #(.WIDTH(16), .STAGES(4), .RESET_VALUE(16'h0000)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir[1]), .out_valid(ov[1]), .out_data(od1), .out_ready(out_ready), .occupancy(occ1));
  pipe_reg #(.WIDTH(8), .STAGES(1), .RESET_VALUE(8'hFF)) u2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data[7:0]),
    .in_ready(ir[2]), .out_valid(ov[2]), .out_data(od2), .out_ready(out_ready), .occupancy(occ2));

  // Model: each held word has a position 0..S-1; index 0 of the list is the oldest word.
  int          ms   [3] = '{2, 4, 1};
  logic [15:0] mw   [3][4];
  int          mpos [3][4];
  int          mcnt [3];
  logic [15:0] mlast[3];

  function automatic int imin(int a, int b);
    return (a < b) ? a : b;
  endfunction

  // Can position 0 be taken after every held word moves as far as it may?
  function automatic bit m_ready(int k, bit orr, bit fl);
    int lim;
    if (fl) return 1'b0;
    lim = orr ? ms[k] : ms[k] - 1;
    for (int j = 0; j < mcnt[k]; j++) lim = imin(mpos[k][j] + 1, lim) - 1;
    return lim >= 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) mcnt[k] = 0;
      mlast[0] = 16'h0000; mlast[1] = 16'h0000; mlast[2] = 16'h00FF;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (flush) begin
          mcnt[k] = 0;
        end else begin
          logic [15:0] nw [4];
          int np [4];
          int nc, lim, p;
          bit acc;
          acc = m_ready(k, out_ready, 1'b0) && in_valid;
          lim = out_ready ? ms[k] : ms[k] - 1;
          nc = 0;
          for (int j = 0; j < mcnt[k]; j++) begin
            p = imin(mpos[k][j] + 1, lim);
            lim = p - 1;
            if (p < ms[k]) begin
              if (p == ms[k] - 1 && mpos[k][j] < ms[k] - 1) mlast[k] = mw[k][j];
              nw[nc] = mw[k][j]; np[nc] = p; nc++;
            end
          end
          if (acc) begin
            nw[nc] = (k == 2) ? (in_data & 16'h00FF) : in_data;
            np[nc] = 0;
            if (ms[k] == 1) mlast[k] = nw[nc];
            nc++;
          end
          for (int j = 0; j < nc; j++) begin
            mw[k][j] = nw[j]; mpos[k][j] = np[j];
          end
          mcnt[k] = nc;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] act_od(int k);
    return (k == 0) ? od0 : (k == 1) ? od1 : {8'h00, od2};
  endfunction
  function automatic logic [15:0] act_occ(int k);
    return (k == 0) ? {14'd0, occ0} : (k == 1) ? {13'd0, occ1} : {15'd0, occ2};
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d.out_valid", k), {15'd0, ov[k]},
          {15'd0, (mcnt[k] > 0 && mpos[k][0] == ms[k] - 1)});
      chk($sformatf("u%0d.out_data", k), act_od(k), mlast[k]);
      chk($sformatf("u%0d.occupancy", k), act_occ(k), 16'(mcnt[k]));
      chk($sformatf("u%0d.in_ready", k), {15'd0, ir[k]},
          {15'd0, m_ready(k, out_ready, flush)});
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    tick(2);
    rst_n = 1'b1;
    chk("rst.ov", {15'd0, ov[0]}, 16'h0000);
    chk("rst.od", od0, 16'h0000);
    chk("rst.occ", {14'd0, occ0}, 16'h0000);
    chk("rst.ir", {15'd0, ir[0]}, 16'h0001);
    chk("rst.od_w8", {8'h00, od2}, 16'h00FF);

    // Streaming
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h0013;
    tick();
    chk("str.ov1", {15'd0, ov[0]}, 16'h0000);
    chk("str.occ1", {14'd0, occ0}, 16'h0001);
    chk("par.ov", {15'd0, ov[2]}, 16'h0001);
    chk("par.od", {8'h00, od2}, 16'h0013);
    in_data = 16'h0031;
    tick();
    chk("str.od2", od0, 16'h0013);
    chk("str.occ2", {14'd0, occ0}, 16'h0002);
    in_data = 16'h0001;
    tick();
    chk("str.od3", od0, 16'h0031);
    chk("str.ov3", {15'd0, ov[0]}, 16'h0001);
    in_valid = 1'b0;
    tick();
    chk("str.od4", od0, 16'h0001);
    chk("str.occ4", {14'd0, occ0}, 16'h0001);
    tick();
    chk("str.ov5", {15'd0, ov[0]}, 16'h0000);
    chk("str.hold", od0, 16'h0001);
    tick(3);

    // Backpressure
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h00AA;
    tick();
    in_data = 16'h00BB;
    tick(2);
    chk("bp.occ", {14'd0, occ0}, 16'h0002);
    chk("bp.ir", {15'd0, ir[0]}, 16'h0000);
    chk("bp.od", od0, 16'h00AA);
    out_ready = 1'b1; in_data = 16'h00CC;
    #1;
    chk("bp.ir_ripple", {15'd0, ir[0]}, 16'h0001);
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    chk("bp.od_after", od0, 16'h00BB);
    chk("bp.occ_after", {14'd0, occ0}, 16'h0002);

    // Flush
    flush = 1'b1; in_valid = 1'b1; in_data = 16'h5555;
    #1;
    chk("fl.ir", {15'd0, ir[0]}, 16'h0000);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl.occ", {14'd0, occ0}, 16'h0000);
    chk("fl.ov", {15'd0, ov[0]}, 16'h0000);
    chk("fl.occ4", {13'd0, occ1}, 16'h0000);
    out_ready = 1'b1;
    tick(2);
    chk("fl.no5555", {15'd0, ov[0]}, 16'h0000);

    // Bubble compression on the 4-stage instance
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h1234;
    tick();
    in_valid = 1'b0;
    chk("bub.occ", {13'd0, occ1}, 16'h0001);
    chk("bub.ir", {15'd0, ir[1]}, 16'h0001);
    tick(2);
    chk("bub.ov_early", {15'd0, ov[1]}, 16'h0000);
    tick();
    chk("bub.ov", {15'd0, ov[1]}, 16'h0001);
    chk("bub.od", od1, 16'h1234);
    tick();
    chk("bub.stay", od1, 16'h1234);
    chk("bub.occ_end", {13'd0, occ1}, 16'h0001);
    chk("bub.ir_end", {15'd0, ir[1]}, 16'h0001);

    // Asynchronous reset mid-cycle with two words held
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b1; in_data = 16'h0013;
    tick();
    in_data = 16'h0031;
    tick();
    in_valid = 1'b0;
    chk("ar.occ_pre", {14'd0, occ0}, 16'h0002);
    #2 rst_n = 1'b0;
    #1;
    chk("ar.ov", {15'd0, ov[0]}, 16'h0000);
    chk("ar.od", od0, 16'h0000);
    chk("ar.occ", {14'd0, occ0}, 16'h0000);
    chk("ar.od_w8", {8'h00, od2}, 16'h00FF);
    tick();
    rst_n = 1'b1;
    chk("ar.ir", {15'd0, ir[0]}, 16'h0001);

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_data   = 16'($urandom);
      tick();
    end
    flush = 1'b0;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_reg.md
Name: pipe_reg

Overview:
- Parametrised successor to the 16-bit D flip-flop register: a STAGES-deep, WIDTH-bit pipeline register with a per-stage valid bit and valid/ready flow control.
- Each stage advances independently, so bubbles compress under backpressure. Adds flush, a reset value and an occupancy count.
- Sits between processor pipeline stages (fetch→decode, decode→execute) and replaces hand-instantiated register chains.

Parameters:
- WIDTH, 16: data width in bits, ≥1.
- STAGES, 2: number of register stages, ≥1.
- RESET_VALUE, 16'h0000 (WIDTH bits): data value loaded into every stage on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous flush; clears all valid bits.
- in_valid  input  1  upstream word present.
- in_data  input  WIDTH  upstream word.
- in_ready  output  1  block accepts in_data this cycle.
- out_valid  output  1  output word present.
- out_data  output  WIDTH  output word.
- out_ready  input  1  downstream accepts the output word.
- occupancy  output  $clog2(STAGES+1)  number of valid stages.

Behaviour:
- Reset:
  - Asserting rst_n=0 immediately, with no clock, clears all v[i] and sets all d[i]=RESET_VALUE.
  - Resulting outputs: out_valid=0, out_data=RESET_VALUE, occupancy=0, in_ready=1 (while flush=0).
  - Reset mid-transfer discards all held words.
- State: stage i (0=input side, STAGES-1=output side) holds v[i] and d[i].
  - out_valid=v[STAGES-1].
  - out_data=d[STAGES-1].
- Advance terms (combinational):
  - adv[STAGES-1] = !v[STAGES-1] | out_ready.
  - adv[i] = !v[i] | adv[i+1].
  - in_ready = adv[0] & !flush.
  - Ready therefore ripples combinationally from out_ready to in_ready. No registered ready is used.
- Clock edge, flush=0: for each i with adv[i]=1:
  - v[i] <= source valid. Source is in_valid for i=0, v[i-1] otherwise.
  - d[i] <= source data only if source valid=1; otherwise d[i] holds.
  - A stage with adv[i]=0 holds both v[i] and d[i].
- Clock edge, flush=1:
  - All v[i] <= 0.
  - d[i] hold.
  - in_ready=0, so no word is accepted in the flush cycle.
  - Flush beats any simultaneous transfer. A word presented with out_valid&out_ready in the flush cycle counts as delivered; the rest are lost.
- Latency:
  - A word accepted at edge k into an empty pipe reaches the output stage at edge k+STAGES-1.
  - out_valid is high in the cycle after that edge.
  - STAGES=1 gives out_valid in the cycle after acceptance.
- Throughput:
  - One word per cycle when out_ready=1 continuously.
  - Simultaneous accept and deliver on a full pipe is legal: everything shifts by one.
- Full pipe with out_ready=0: every v=1, so in_ready=0 and contents are stable.
- Bubble compression: with out_ready=0, a word behind an empty stage still advances until it abuts the next valid stage.
- occupancy:
  - Registered population count of v[]. Updates on the same edge as v[].
  - Range 0..STAGES.
- Ordering: words exit in acceptance order. None are duplicated or dropped except by flush or reset.
- out_data holds its last value while out_valid=0.

Test Plan (default WIDTH=16, STAGES=2 unless noted):
- Reset:
  - Stimulus: rst_n=0 asynchronously mid-cycle with both stages holding 16'h0013 and 16'h0031.
  - Required: out_valid=0, out_data=16'h0000 and occupancy=0 before the next clk edge; in_ready=1 after release.
- Streaming:
  - Stimulus: out_ready=1; in_valid=1 with in_data 16'h0013, 16'h0031, 16'h0001 on consecutive edges.
  - Required: out_data is 16'h0013, 16'h0031, 16'h0001 in the cycles after edges 2, 3 and 4; out_valid continuous; occupancy peaks at 2.
- Backpressure:
  - Stimulus: out_ready=0; feed 16'h00AA, 16'h00BB.
  - Required: occupancy=2, in_ready=0, out_data=16'h00AA stable.
  - Then: raise out_ready for one cycle while in_valid=1 with 16'h00CC.
  - Required: 16'h00AA delivered, pipe becomes {16'h00CC, 16'h00BB}, occupancy stays 2.
- Bubble compression:
  - Stimulus: out_ready=0, STAGES=4; one word 16'h1234 accepted.
  - Required: 16'h1234 reaches the output stage after 3 more edges and stops there; occupancy=1 and in_ready=1 throughout.
- Flush:
  - Stimulus: pipe holding 2 words; flush=1 for one edge while in_valid=1 with 16'h5555.
  - Required: in_ready=0 during the flush cycle; afterwards occupancy=0 and out_valid=0; 16'h5555 never appears at the output.
- Parametrisation:
  - Stimulus: WIDTH=8, STAGES=1, RESET_VALUE=8'hFF.
  - Required: out_data=8'hFF after reset; a word accepted at edge k is valid at the output in cycle k+1; occupancy is 1 bit wide.
